// File: rtl/camera_pkg.sv
// Shared definitions for the camera capture path: FSM encoding, default
// geometry and the byte order used when pairing camera bytes into words.
package camera_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_WAIT_SOF = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_DONE     = 3'd4
  } cam_state_e;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_ADDR_W     = 19;

  // UYVY: the first byte of each pair lands in the upper half of the word.
  localparam logic UYVY_FIRST_HI = 1'b1;

  function automatic logic [15:0] pack_uyvy(input logic [7:0] first_b,
                                            input logic [7:0] second_b);
    if (UYVY_FIRST_HI) begin
      return {first_b, second_b};
    end else begin
      return {second_b, first_b};
    end
  endfunction

endpackage

// File: rtl/cam_input_sync.sv
// Brings the asynchronous camera bus into clk_25 and produces edge strobes
// for pclk/href/vsyn, all aligned with the delayed levels and data byte.
module cam_input_sync (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       cam_pclk,
  input  logic       cam_href,
  input  logic       cam_vsyn,
  input  logic [7:0] cam_data,
  output logic       pclk_rise,
  output logic       href_lvl,
  output logic       href_rise,
  output logic       href_fall,
  output logic       vsyn_lvl,
  output logic       vsyn_rise,
  output logic       vsyn_fall,
  output logic [7:0] data_lvl
);

  logic       pclk_meta_r, pclk_sync_r, pclk_dly_r;
  logic       href_meta_r, href_sync_r, href_dly_r;
  logic       vsyn_meta_r, vsyn_sync_r, vsyn_dly_r;
  logic [7:0] data_meta_r, data_sync_r, data_dly_r;
  logic       pclk_rise_r, href_rise_r, href_fall_r, vsyn_rise_r, vsyn_fall_r;

  // Two-flop synchronizers, a third stage for edge detection, registered strobes.
  always_ff @(posedge clk_25) begin
    if (!rst) begin
      pclk_meta_r <= 1'b0;
      pclk_sync_r <= 1'b0;
      pclk_dly_r  <= 1'b0;
      href_meta_r <= 1'b0;
      href_sync_r <= 1'b0;
      href_dly_r  <= 1'b0;
      vsyn_meta_r <= 1'b0;
      vsyn_sync_r <= 1'b0;
      vsyn_dly_r  <= 1'b0;
      data_meta_r <= 8'h00;
      data_sync_r <= 8'h00;
      data_dly_r  <= 8'h00;
      pclk_rise_r <= 1'b0;
      href_rise_r <= 1'b0;
      href_fall_r <= 1'b0;
      vsyn_rise_r <= 1'b0;
      vsyn_fall_r <= 1'b0;
    end else begin
      pclk_meta_r <= cam_pclk;
      pclk_sync_r <= pclk_meta_r;
      pclk_dly_r  <= pclk_sync_r;
      href_meta_r <= cam_href;
      href_sync_r <= href_meta_r;
      href_dly_r  <= href_sync_r;
      vsyn_meta_r <= cam_vsyn;
      vsyn_sync_r <= vsyn_meta_r;
      vsyn_dly_r  <= vsyn_sync_r;
      data_meta_r <= cam_data;
      data_sync_r <= data_meta_r;
      data_dly_r  <= data_sync_r;
      pclk_rise_r <= pclk_sync_r & ~pclk_dly_r;
      href_rise_r <= href_sync_r & ~href_dly_r;
      href_fall_r <= ~href_sync_r & href_dly_r;
      vsyn_rise_r <= vsyn_sync_r & ~vsyn_dly_r;
      vsyn_fall_r <= ~vsyn_sync_r & vsyn_dly_r;
    end
  end

  assign pclk_rise = pclk_rise_r;
  assign href_lvl  = href_dly_r;
  assign href_rise = href_rise_r;
  assign href_fall = href_fall_r;
  assign vsyn_lvl  = vsyn_dly_r;
  assign vsyn_rise = vsyn_rise_r;
  assign vsyn_fall = vsyn_fall_r;
  assign data_lvl  = data_dly_r;

endmodule

// File: rtl/camera_capture.sv
// Single-frame capture of the camera byte stream into addressed 16-bit UYVY
// words, with a sticky flag for lines that do not carry 2*IMG_WIDTH bytes.
module camera_capture
  import camera_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              configure_over,
  input  logic              capture_start,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsyn,
  input  logic [7:0]        cam_data,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              capturing,
  output logic              frame_done,
  output logic              line_err
);

  localparam int COL_W = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam int CNT_W = $clog2(2 * IMG_WIDTH + 2) + 1;
  localparam logic [COL_W-1:0] COL_LIM  = COL_W'(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(IMG_HEIGHT);
  localparam logic [CNT_W-1:0] CNT_LINE = CNT_W'(2 * IMG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic       pclk_rise_s, href_s, href_rise_s, href_fall_s;
  logic       vsyn_s, vsyn_rise_s, vsyn_fall_s;
  logic [7:0] data_s;

  cam_input_sync u_sync (
    .clk_25    (clk_25),
    .rst       (rst),
    .cam_pclk  (cam_pclk),
    .cam_href  (cam_href),
    .cam_vsyn  (cam_vsyn),
    .cam_data  (cam_data),
    .pclk_rise (pclk_rise_s),
    .href_lvl  (href_s),
    .href_rise (href_rise_s),
    .href_fall (href_fall_s),
    .vsyn_lvl  (vsyn_s),
    .vsyn_rise (vsyn_rise_s),
    .vsyn_fall (vsyn_fall_s),
    .data_lvl  (data_s)
  );

  cam_state_e        state_r, state_nx_s;
  logic              phase_r, line_open_r;
  logic [7:0]        hold_r;
  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [CNT_W-1:0]  byte_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       pix_data_r;
  logic              pix_valid_r, capturing_r, frame_done_r, line_err_r;

  logic              start_ok_s, phase_eff_s, in_window_s;
  logic [CNT_W-1:0]  cnt_base_s, cnt_inc_s;
  logic [ROW_W-1:0]  row_inc_s;

  assign start_ok_s  = capture_start & configure_over;
  // A byte arriving together with href rise belongs to the new line.
  assign phase_eff_s = href_rise_s ? 1'b0 : phase_r;
  assign cnt_base_s  = href_rise_s ? {CNT_W{1'b0}} : byte_cnt_r;
  assign cnt_inc_s   = (cnt_base_s == CNT_MAX) ? CNT_MAX : cnt_base_s + CNT_W'(1'b1);
  assign row_inc_s   = (row_r == ROW_LIM) ? ROW_LIM : row_r + ROW_W'(1'b1);
  assign in_window_s = (col_r < COL_LIM) && (row_r < ROW_LIM);

  // FSM state register.
  always_ff @(posedge clk_25) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_nx_s = ST_ARMED;
        else            state_nx_s = ST_IDLE;
      end
      ST_ARMED: begin
        if (vsyn_s) state_nx_s = ST_WAIT_SOF;
        else        state_nx_s = ST_ARMED;
      end
      ST_WAIT_SOF: begin
        if (vsyn_fall_s) state_nx_s = ST_CAPTURE;
        else             state_nx_s = ST_WAIT_SOF;
      end
      ST_CAPTURE: begin
        if (vsyn_rise_s) state_nx_s = ST_DONE;
        else             state_nx_s = ST_CAPTURE;
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Byte pairing, counters, address generation and registered outputs.
  always_ff @(posedge clk_25) begin
    if (!rst) begin
      phase_r      <= 1'b0;
      line_open_r  <= 1'b0;
      hold_r       <= 8'h00;
      col_r        <= {COL_W{1'b0}};
      row_r        <= {ROW_W{1'b0}};
      byte_cnt_r   <= {CNT_W{1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      pix_data_r   <= 16'h0000;
      pix_valid_r  <= 1'b0;
      capturing_r  <= 1'b0;
      frame_done_r <= 1'b0;
      line_err_r   <= 1'b0;
    end else begin
      pix_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      if (pix_valid_r) begin
        addr_r <= addr_r + ADDR_W'(1'b1);
      end
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) line_err_r <= 1'b0;
        end
        ST_WAIT_SOF: begin
          if (vsyn_fall_s) begin
            addr_r      <= {ADDR_W{1'b0}};
            col_r       <= {COL_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            byte_cnt_r  <= {CNT_W{1'b0}};
            phase_r     <= 1'b0;
            line_open_r <= 1'b0;
            capturing_r <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (href_rise_s) begin
            phase_r     <= 1'b0;
            byte_cnt_r  <= {CNT_W{1'b0}};
            line_open_r <= 1'b1;
          end
          if (pclk_rise_s && href_s) begin
            byte_cnt_r <= cnt_inc_s;
            if (!phase_eff_s) begin
              hold_r  <= data_s;
              phase_r <= 1'b1;
            end else begin
              phase_r <= 1'b0;
              if (in_window_s) begin
                pix_valid_r <= 1'b1;
                pix_data_r  <= pack_uyvy(hold_r, data_s);
                col_r       <= col_r + COL_W'(1'b1);
              end
            end
          end
          if (href_fall_s) begin
            row_r       <= row_inc_s;
            col_r       <= {COL_W{1'b0}};
            line_open_r <= 1'b0;
            if (byte_cnt_r != CNT_LINE) line_err_r <= 1'b1;
          end
          // Frame ended inside a line whose href fall was never seen.
          if (vsyn_rise_s && line_open_r && !href_fall_s) begin
            line_err_r <= 1'b1;
          end
        end
        ST_DONE: begin
          frame_done_r <= 1'b1;
          capturing_r  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign pix_data   = pix_data_r;
  assign pix_valid  = pix_valid_r;
  assign pix_addr   = addr_r;
  assign capturing  = capturing_r;
  assign frame_done = frame_done_r;
  assign line_err   = line_err_r;

endmodule
